reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Multi-writer register scoreboard for the RV32I core; successor to the single-producer status table.
//  Tracks, per architectural register, the number of in-flight writes and a latency countdown to bypass availability.
//  Also records the class (load / non-load) of the youngest writer.
//  Sits between ID (issue / source lookup) and the variable-latency EX/MEM/WB back-end.
//  Drives stall, forward-ready and load-use classification into hazard control.
// PARAMETERS
//  NUM_REGS     32  architectural registers; x0 is hard-wired never-busy
//  NUM_SRC      2   source lookup ports (rs1, rs2, ...)
//  NUM_WB       2   writeback (retire) ports
//  MAX_PEND     3   max in-flight writes per register; CNT_W = $clog2(MAX_PEND+1)
//  LAT_W        3   width of issue latency field (cycles until result is forwardable)
// PORTS
//  clk             in   1                 clock, all state on rising edge
//  rst_n           in   1                 asynchronous, active-low reset
//  flush           in   1                 kill all in-flight producers (redirect/trap)
//  issue_valid     in   1                 ID issues an instruction writing issue_rd
//  issue_ready     out  1                 issue accepted this cycle
//  issue_rd        in   5                 destination register
//  issue_is_load   in   1                 producer is a load
//  issue_lat       in   LAT_W             cycles until result reaches bypass network
//  wb_valid        in   NUM_WB            writeback port p retires a write
//  wb_rd           in   NUM_WB*5          destination per writeback port
//  src_rs          in   NUM_SRC*5         source register per lookup port
//  src_use         in   NUM_SRC           lookup port actually reads its register
//  src_hazard      out  NUM_SRC           pending write, result not yet forwardable -> stall
//  src_fwd_ok      out  NUM_SRC           pending write, result forwardable this cycle
//  src_is_load     out  NUM_SRC           youngest pending writer is a load (qualified by pending)
//  busy_vec        out  NUM_REGS          busy bit per register (count != 0)
//  busy_count      out  $clog2(NUM_REGS+1)  popcount of busy_vec
//  underflow_err   out  1                 sticky: writeback to a register with count 0
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - all counts, countdowns and load bits cleared
//    - busy_vec=0, busy_count=0, underflow_err=0, src_* = 0
//    - issue_ready=1 once the reset is released.
//  - Issue handshake:
//    - fire = issue_valid && issue_ready.
//    - issue_ready = !(cnt[issue_rd]==MAX_PEND) && !flush; combinational.
//    - fire with issue_rd=0 is accepted with no state change.
//  - On fire (rd!=0), next edge:
//    - cnt[rd]++
//    - lat[rd] <= issue_lat; youngest writer owns the countdown
//    - load[rd] <= issue_is_load
//  - Countdown: each cycle, any lat[r]!=0 that is not reloaded decrements by 1, saturating at 0.
//  - Writeback:
//    - each wb_valid[p] with rd!=0 decrements cnt[rd]; lat/load bits are untouched.
//    - two wb ports on the same rd in one cycle decrement by 2.
//    - if the decrement would go below 0: cnt clamps at 0 and underflow_err sets (sticky until reset).
//  - Simultaneous issue + writeback on the same rd: net cnt = cnt + 1 - n_wb; issue fields win.
//    - underflow is evaluated against cnt+1.
//  - Flush is synchronous and has highest priority.
//    - all cnt, lat and load bits <= 0; same-cycle issue/wb ignored.
//    - underflow_err is NOT cleared.
//  - Source lookup is combinational (zero latency). With pend = src_use && cnt[rs]!=0 && rs!=0:
//    - src_hazard = pend && lat[rs]!=0
//    - src_fwd_ok = pend && lat[rs]==0
//    - src_is_load = pend && load[rs]
//  - Same-cycle issue and lookup: state is visible from the next cycle only; no issue->lookup bypass.
//  - busy_vec and busy_count are combinational from registered cnt; busy_vec[0] is always 0.
// STRUCTURE
//  - Package core_sb_pkg:
//    - constants NUM_REGS_DEF, MAX_PEND_DEF
//    - typedef sb_entry_t {cnt, lat, load}
//    - function popcount.
//  - Sub-module reg_scoreboard_entry: one per register (generate).
//    - holds cnt/lat/load
//    - inputs: issue_hit, wb_hits (count), flush
//    - outputs: busy, fwd_ok, is_load, full.
//  - Top level: decode, issue_ready mux, lookup muxes, popcount, sticky error.
// TESTING
//  - Reset mid-operation:
//    - issue x5 lat=2, then assert rst_n=0 asynchronously.
//    - expect busy_vec=0 and underflow_err=0 immediately, without waiting for a clock edge.
//  - Latency countdown:
//    - issue x7 lat=2, non-load; look up x7.
//    - expect src_hazard=1 on cycles +1 and +2, then src_fwd_ok=1 from +3 until wb on x7.
//    - after wb on x7: busy_vec[7]=0.
//  - Load-use classification:
//    - issue x3 load lat=1; look up x3 next cycle.
//    - expect src_hazard=1 and src_is_load=1; src_use=0 masks all src_* outputs to 0.
//  - WAW saturation:
//    - issue x9 three times with no wb: cnt=3.
//    - 4th issue: issue_ready=0.
//    - one wb on x9 then issue again: accepted, cnt=3.
//  - Simultaneous events:
//    - cnt[x4]=1; same cycle: issue x4 (load, lat=0) + wb x4.
//    - expect cnt=1, src_is_load=1, src_fwd_ok=1.
//    - second test, cnt[x4]=1: dual wb on x4 -> cnt=0, underflow_err=1.
//  - Flush and x0:
//    - issue x1,x2,x3, then flush together with issue x6.
//    - expect busy_count=0 and x6 not busy.
//    - issue x0: issue_ready=1, busy_vec unchanged.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants, per-register state layout and lookup response type for the
// multi-writer register scoreboard.
package core_sb_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int MAX_PEND_DEF = 3;
  localparam int CNT_W_DEF    = $clog2(MAX_PEND_DEF + 1);
  localparam int LAT_W_DEF    = 3;
  localparam int REG_W        = 5;
  localparam int POP_W        = $clog2(NUM_REGS_DEF + 1);

  typedef struct packed {
    logic [CNT_W_DEF-1:0] cnt;
    logic [LAT_W_DEF-1:0] lat;
    logic                 load;
  } sb_entry_t;

  typedef struct packed {
    logic hazard;
    logic fwd_ok;
    logic is_load;
  } sb_src_rsp_t;

  function automatic logic [POP_W-1:0] popcount(input logic [NUM_REGS_DEF-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS_DEF; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/reg_scoreboard_entry.sv
// One scoreboard slot: pending-write count, youngest-writer latency countdown
// and load flag for a single architectural register.
module reg_scoreboard_entry
  import core_sb_pkg::*;
#(
  parameter int NUM_WB   = 2,
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int LAT_W    = LAT_W_DEF,
  parameter int WB_W     = $clog2(NUM_WB + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_hit,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             issue_is_load,
  input  logic [WB_W-1:0]  wb_hits,
  output logic             busy,
  output logic             fwd_ok,
  output logic             is_load,
  output logic             full,
  output logic             underflow
);

  localparam int EW = CNT_W_DEF + WB_W;

  sb_entry_t            ent_q;
  logic [EW-1:0]        base;
  logic [EW-1:0]        wb_ext;
  logic [CNT_W_DEF-1:0] cnt_nxt;

  // Issue lands before retirement, so underflow is judged against cnt+issue.
  always_comb begin
    base      = EW'(ent_q.cnt) + EW'(issue_hit);
    wb_ext    = EW'(wb_hits);
    underflow = !flush && (wb_ext > base);
    cnt_nxt   = underflow ? '0 : CNT_W_DEF'(base - wb_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else if (flush) begin
      ent_q <= '0;
    end else begin
      ent_q.cnt <= cnt_nxt;
      if (issue_hit) begin
        ent_q.lat  <= issue_lat;
        ent_q.load <= issue_is_load;
      end else if (ent_q.lat != '0) begin
        ent_q.lat <= ent_q.lat - 1'b1;
      end
    end
  end

  assign busy    = (ent_q.cnt != '0);
  assign fwd_ok  = (ent_q.lat == '0);
  assign is_load = ent_q.load;
  assign full    = (ent_q.cnt == CNT_W_DEF'(MAX_PEND));

endmodule

// File: rtl/reg_scoreboard.sv
// Multi-writer register scoreboard: issue decode, per-register entries,
// zero-latency source lookup, busy popcount and sticky underflow flag.
module reg_scoreboard
  import core_sb_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_SRC  = 2,
  parameter int NUM_WB   = 2,
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int LAT_W    = LAT_W_DEF,
  parameter int BC_W     = $clog2(NUM_REGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_is_load,
  input  logic [LAT_W-1:0]         issue_lat,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*5-1:0]      wb_rd,
  input  logic [NUM_SRC*5-1:0]     src_rs,
  input  logic [NUM_SRC-1:0]       src_use,
  output logic [NUM_SRC-1:0]       src_hazard,
  output logic [NUM_SRC-1:0]       src_fwd_ok,
  output logic [NUM_SRC-1:0]       src_is_load,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [BC_W-1:0]          busy_count,
  output logic                     underflow_err
);

  localparam int WB_W = $clog2(NUM_WB + 1);

  logic [NUM_WB-1:0][REG_W-1:0]  wb_rd_a;
  logic [NUM_SRC-1:0][REG_W-1:0] src_rs_a;
  logic [NUM_REGS-1:0]           busy, lat_zero, ld, full, uf, issue_hit;
  logic [NUM_REGS-1:0][WB_W-1:0] wb_hits;
  sb_src_rsp_t [NUM_SRC-1:0]     rsp;
  logic                          fire;

  assign wb_rd_a  = wb_rd;
  assign src_rs_a = src_rs;

  assign issue_ready = !full[issue_rd] && !flush;
  assign fire        = issue_valid && issue_ready;

  // Count retirements per register; two ports on one rd yield a hit count of 2.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wb_hits[r] = '0;
      for (int p = 0; p < NUM_WB; p++)
        if (r != 0 && wb_valid[p] && wb_rd_a[p] == REG_W'(r))
          wb_hits[r] = wb_hits[r] + WB_W'(1);
    end
  end

  genvar r;
  generate
    for (r = 0; r < NUM_REGS; r++) begin : g_ent
      assign issue_hit[r] = (r != 0) && fire && (issue_rd == REG_W'(r));
      reg_scoreboard_entry #(
        .NUM_WB   (NUM_WB),
        .MAX_PEND (MAX_PEND),
        .LAT_W    (LAT_W)
      ) u_ent (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .issue_hit     (issue_hit[r]),
        .issue_lat     (issue_lat),
        .issue_is_load (issue_is_load),
        .wb_hits       (wb_hits[r]),
        .busy          (busy[r]),
        .fwd_ok        (lat_zero[r]),
        .is_load       (ld[r]),
        .full          (full[r]),
        .underflow     (uf[r])
      );
    end
  endgenerate

  // Lookups see registered state only; a same-cycle issue is not bypassed.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      logic pend;
      pend           = src_use[s] && (src_rs_a[s] != '0) && busy[src_rs_a[s]];
      rsp[s].hazard  = pend && !lat_zero[src_rs_a[s]];
      rsp[s].fwd_ok  = pend && lat_zero[src_rs_a[s]];
      rsp[s].is_load = pend && ld[src_rs_a[s]];
    end
  end

  genvar s;
  generate
    for (s = 0; s < NUM_SRC; s++) begin : g_src
      assign src_hazard[s]  = rsp[s].hazard;
      assign src_fwd_ok[s]  = rsp[s].fwd_ok;
      assign src_is_load[s] = rsp[s].is_load;
    end
  endgenerate

  always_comb begin
    busy_vec    = busy;
    busy_vec[0] = 1'b0;
  end

  assign busy_count = BC_W'(popcount(NUM_REGS_DEF'(busy_vec)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   underflow_err <= 1'b0;
    else if (|uf) underflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: inputs change on the falling edge,
// outputs are checked mid-cycle against hand-computed values.
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rd;
  logic        issue_is_load;
  logic [2:0]  issue_lat;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic [9:0]  src_rs;
  logic [1:0]  src_use;
  logic [1:0]  src_hazard, src_fwd_ok, src_is_load;
  logic [31:0] busy_vec;
  logic [5:0]  busy_count;
  logic        underflow_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .issue_is_load(issue_is_load), .issue_lat(issue_lat),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .src_rs(src_rs), .src_use(src_use),
    .src_hazard(src_hazard), .src_fwd_ok(src_fwd_ok), .src_is_load(src_is_load),
    .busy_vec(busy_vec), .busy_count(busy_count), .underflow_err(underflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] rd, input logic load, input logic [2:0] lat);
    issue_valid = 1'b1; issue_rd = rd; issue_is_load = load; issue_lat = lat;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic wb(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1);
    wb_valid = v; wb_rd = {r1, r0};
    @(negedge clk);
    wb_valid = 2'b00;
  endtask

  task automatic look(input logic [1:0] use_m, input logic [4:0] r0, input logic [4:0] r1);
    src_use = use_m; src_rs = {r1, r0};
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    issue_is_load = 1'b0; issue_lat = '0; wb_valid = '0; wb_rd = '0;
    src_rs = '0; src_use = '0;
    #12;
    chk("rst_busy_vec", busy_vec, 32'h0);
    chk("rst_busy_count", 32'(busy_count), 0);
    chk("rst_underflow", 32'(underflow_err), 0);
    chk("rst_src", {26'h0, src_hazard, src_fwd_ok, src_is_load}, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_issue_ready", 32'(issue_ready), 1);
    @(negedge clk);

    // Latency countdown on x7
    issue(5'd7, 1'b0, 3'd2);
    look(2'b01, 5'd7, 5'd0);
    chk("lat_c1_hazard", 32'(src_hazard), 1);
    chk("lat_c1_fwd", 32'(src_fwd_ok), 0);
    chk("lat_busy_count", 32'(busy_count), 1);
    @(negedge clk); #1;
    chk("lat_c2_hazard", 32'(src_hazard), 1);
    @(negedge clk); #1;
    chk("lat_c3_hazard", 32'(src_hazard), 0);
    chk("lat_c3_fwd", 32'(src_fwd_ok), 1);
    @(negedge clk); #1;
    chk("lat_c4_fwd", 32'(src_fwd_ok), 1);
    wb(2'b01, 5'd7, 5'd0); #1;
    chk("lat_wb_busy7", 32'(busy_vec[7]), 0);
    chk("lat_wb_fwd", 32'(src_fwd_ok), 0);

    // Load-use on x3 via lookup port 1
    issue(5'd3, 1'b1, 3'd1);
    look(2'b10, 5'd0, 5'd3);
    chk("ld_hazard", 32'(src_hazard), 32'h2);
    chk("ld_is_load", 32'(src_is_load), 32'h2);
    chk("ld_fwd", 32'(src_fwd_ok), 0);
    look(2'b00, 5'd3, 5'd3);
    chk("ld_nouse", {26'h0, src_hazard, src_fwd_ok, src_is_load}, 0);
    wb(2'b01, 5'd3, 5'd0);

    // WAW saturation on x9
    issue(5'd9, 1'b0, 3'd0);
    issue(5'd9, 1'b0, 3'd0);
    issue(5'd9, 1'b0, 3'd0);
    issue_rd = 5'd9; #1;
    chk("waw_full_ready", 32'(issue_ready), 0);
    chk("waw_busy_count", 32'(busy_count), 1);
    wb(2'b10, 5'd0, 5'd9); #1;
    chk("waw_after_wb_ready", 32'(issue_ready), 1);
    issue(5'd9, 1'b0, 3'd0);
    issue_rd = 5'd9; #1;
    chk("waw_refull_ready", 32'(issue_ready), 0);
    wb(2'b11, 5'd9, 5'd9); #1;
    chk("waw_cnt1_busy", 32'(busy_vec[9]), 1);
    wb(2'b01, 5'd9, 5'd0); #1;
    chk("waw_drain_busy", 32'(busy_vec[9]), 0);
    chk("waw_no_underflow", 32'(underflow_err), 0);

    // Simultaneous issue + wb on x4
    issue(5'd4, 1'b0, 3'd3);
    wb_valid = 2'b01; wb_rd = {5'd0, 5'd4};
    issue(5'd4, 1'b1, 3'd0);
    wb_valid = 2'b00;
    look(2'b01, 5'd4, 5'd0);
    chk("sim_is_load", 32'(src_is_load), 1);
    chk("sim_fwd_ok", 32'(src_fwd_ok), 1);
    chk("sim_hazard", 32'(src_hazard), 0);
    chk("sim_busy4", 32'(busy_vec[4]), 1);
    chk("sim_no_underflow", 32'(underflow_err), 0);
    wb(2'b01, 5'd4, 5'd0); #1;
    chk("sim_cnt1_cleared", 32'(busy_vec[4]), 0);
    issue(5'd4, 1'b0, 3'd0);
    wb(2'b11, 5'd4, 5'd4); #1;
    chk("uf_busy4", 32'(busy_vec[4]), 0);
    chk("uf_set", 32'(underflow_err), 1);
    @(negedge clk); #1;
    chk("uf_sticky", 32'(underflow_err), 1);

    // Flush and x0
    issue(5'd1, 1'b0, 3'd1);
    issue(5'd2, 1'b0, 3'd1);
    issue(5'd3, 1'b0, 3'd1); #1;
    chk("fl_pre_count", 32'(busy_count), 3);
    chk("fl_pre_vec", busy_vec, 32'h0000_000E);
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd6; #1;
    chk("fl_ready_low", 32'(issue_ready), 0);
    @(negedge clk);
    flush = 1'b0; issue_valid = 1'b0; #1;
    chk("fl_count", 32'(busy_count), 0);
    chk("fl_busy6", 32'(busy_vec[6]), 0);
    chk("fl_keeps_uf", 32'(underflow_err), 1);
    issue_rd = 5'd0; #1;
    chk("x0_ready", 32'(issue_ready), 1);
    issue(5'd0, 1'b1, 3'd4); #1;
    chk("x0_busy_vec", busy_vec, 32'h0);
    look(2'b11, 5'd0, 5'd0);
    chk("x0_lookup", {26'h0, src_hazard, src_fwd_ok, src_is_load}, 0);

    // Asynchronous reset mid-operation
    issue(5'd5, 1'b0, 3'd2); #1;
    chk("ar_pre_busy5", 32'(busy_vec[5]), 1);
    #2 rst_n = 1'b0; #1;
    chk("ar_busy_vec", busy_vec, 32'h0);
    chk("ar_underflow", 32'(underflow_err), 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("ar_ready", 32'(issue_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
